// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - hardwired control FSM for the elementary CPU; optional single-step via SEQ_SINGLE_STEP_EN
module cpu_sequencer #(
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_dec,
    input  logic        i_flag_z,
    input  logic        i_flag_c,
    input  logic        i_mem_rdy,
    input  logic        i_step,
    output logic        o_dec_en,
    output logic        o_ir_ld,
    output logic        o_opnd_ld,
    output logic        o_pc_inc,
    output logic        o_pc_ld,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_addr_sel,
    output logic        o_reg_we,
    output logic [2:0]  o_alu_op,
    output logic        o_flag_ld,
    output logic        o_io_rd,
    output logic        o_io_wr,
    output logic        o_halted,
    output logic        o_fault
);

    // Strobe positions in the decoder word (LSB = MOVA)
    localparam int B_MOVA = 0,  B_MOVB = 1,  B_MOVC = 2,  B_ADD  = 3;
    localparam int B_SUB  = 4,  B_AND  = 5,  B_NOT  = 6,  B_RSR  = 7;
    localparam int B_RSL  = 8,  B_JMP  = 9,  B_JZ   = 10, B_JC   = 11;
    localparam int B_IN   = 12, B_OUT  = 13, B_NOP  = 14, B_HALT = 15;

`ifdef SEQ_SINGLE_STEP_EN
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPND, S_EXEC, S_MEM, S_HALT, S_FAULT, S_PAUSE
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPND, S_EXEC, S_MEM, S_HALT, S_FAULT
    } state_t;
`endif

    state_t           r_state;
    state_t           w_next;
    state_t           w_done;
    logic [15:0]      r_strb;
    logic [TMO_W-1:0] r_tmo;
    logic             w_wait;
    logic             w_tmo_hit;
    logic             w_multi;
    logic             w_need_opnd;
    logic             w_is_jump;

`ifdef SEQ_SINGLE_STEP_EN
    assign w_done = S_PAUSE;
`else
    logic w_unused_step;
    assign w_unused_step = i_step;
    assign w_done        = S_FETCH;
`endif

    // More than one strobe hot is an illegal decode; none hot is a NOP
    assign w_multi     = (i_dec & (i_dec - 16'd1)) != 16'd0;
    assign w_need_opnd = i_dec[B_JMP] | i_dec[B_JZ] | i_dec[B_JC] | i_dec[B_MOVB] | i_dec[B_MOVC];
    assign w_is_jump   = r_strb[B_JMP] | r_strb[B_JZ] | r_strb[B_JC];
    // Timeout fires on the last allowed wait cycle only if ready is still absent
    assign w_tmo_hit   = !i_mem_rdy && (r_tmo == TMO_W'(TMO_MAX - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Latch decoder strobes at the end of DECODE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                   r_strb <= '0;
        else if (r_state == S_DECODE)   r_strb <= i_dec;
    end

    // Memory wait counter: restarts on every state change, counts not-ready cycles while waiting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                   r_tmo <= '0;
        else if (w_next != r_state)     r_tmo <= '0;
        else if (w_wait && !i_mem_rdy)  r_tmo <= r_tmo + 1'b1;
    end

    // Next-state and output decode
    always_comb begin
        w_next     = r_state;
        w_wait     = 1'b0;
        o_dec_en   = 1'b0;
        o_ir_ld    = 1'b0;
        o_opnd_ld  = 1'b0;
        o_pc_inc   = 1'b0;
        o_pc_ld    = 1'b0;
        o_mem_rd   = 1'b0;
        o_mem_wr   = 1'b0;
        o_addr_sel = 1'b0;
        o_reg_we   = 1'b0;
        o_alu_op   = 3'b111;
        o_flag_ld  = 1'b0;
        o_io_rd    = 1'b0;
        o_io_wr    = 1'b0;
        o_halted   = 1'b0;
        o_fault    = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                o_mem_rd = 1'b1;
                w_wait   = 1'b1;
                if (i_mem_rdy) begin
                    o_ir_ld  = 1'b1;
                    o_pc_inc = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_tmo_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                o_dec_en = 1'b1;
                if (w_multi)          w_next = S_FAULT;
                else if (w_need_opnd) w_next = S_OPND;
                else                  w_next = S_EXEC;
            end
            S_OPND: begin
                o_mem_rd = 1'b1;
                w_wait   = 1'b1;
                if (i_mem_rdy) begin
                    o_opnd_ld = 1'b1;
                    o_pc_inc  = 1'b1;
                    w_next    = w_is_jump ? S_EXEC : S_MEM;
                end else if (w_tmo_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_EXEC: begin
                w_next = w_done;
                if (r_strb[B_MOVA]) begin o_alu_op = 3'b000; o_reg_we = 1'b1; end
                if (r_strb[B_ADD])  begin o_alu_op = 3'b001; o_reg_we = 1'b1; o_flag_ld = 1'b1; end
                if (r_strb[B_SUB])  begin o_alu_op = 3'b010; o_reg_we = 1'b1; o_flag_ld = 1'b1; end
                if (r_strb[B_AND])  begin o_alu_op = 3'b011; o_reg_we = 1'b1; o_flag_ld = 1'b1; end
                if (r_strb[B_NOT])  begin o_alu_op = 3'b100; o_reg_we = 1'b1; o_flag_ld = 1'b1; end
                if (r_strb[B_RSR])  begin o_alu_op = 3'b101; o_reg_we = 1'b1; o_flag_ld = 1'b1; end
                if (r_strb[B_RSL])  begin o_alu_op = 3'b110; o_reg_we = 1'b1; o_flag_ld = 1'b1; end
                if (r_strb[B_IN])   begin o_io_rd = 1'b1; o_reg_we = 1'b1; end
                if (r_strb[B_OUT])  o_io_wr = 1'b1;
                if (r_strb[B_JMP])  o_pc_ld = 1'b1;
                if (r_strb[B_JZ])   o_pc_ld = i_flag_z;
                if (r_strb[B_JC])   o_pc_ld = i_flag_c;
                if (r_strb[B_HALT]) w_next  = S_HALT;
            end
            S_MEM: begin
                o_addr_sel = 1'b1;
                o_mem_wr   = r_strb[B_MOVB];
                o_mem_rd   = r_strb[B_MOVC];
                w_wait     = 1'b1;
                if (i_mem_rdy) begin
                    o_reg_we = r_strb[B_MOVC];
                    w_next   = w_done;
                end else if (w_tmo_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_HALT:  o_halted = 1'b1;
            S_FAULT: o_fault  = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: if (i_step) w_next = S_FETCH;
`endif
            default: w_next = S_FAULT;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - instruction-level model and per-cycle checker for cpu_sequencer
module tb_cpu_sequencer;

    localparam int TMO_MAX = 12;

    typedef logic [16:0] ovec_t;
    typedef struct packed {
        logic        rst_n;
        logic [15:0] dec;
        logic        fz;
        logic        fc;
        logic        rdy;
        logic        step;
    } stim_t;

    localparam ovec_t O_DEC_EN   = 17'h10000;
    localparam ovec_t O_IR_LD    = 17'h08000;
    localparam ovec_t O_OPND_LD  = 17'h04000;
    localparam ovec_t O_PC_INC   = 17'h02000;
    localparam ovec_t O_PC_LD    = 17'h01000;
    localparam ovec_t O_MEM_RD   = 17'h00800;
    localparam ovec_t O_MEM_WR   = 17'h00400;
    localparam ovec_t O_ADDR_SEL = 17'h00200;
    localparam ovec_t O_REG_WE   = 17'h00100;
    localparam ovec_t O_FLAG_LD  = 17'h00010;
    localparam ovec_t O_IO_RD    = 17'h00008;
    localparam ovec_t O_IO_WR    = 17'h00004;
    localparam ovec_t O_HALTED   = 17'h00002;
    localparam ovec_t O_FAULT    = 17'h00001;
    localparam ovec_t A_IDLE     = 17'h000E0;

    localparam logic [15:0] MOVA = 16'h0001, MOVB = 16'h0002, MOVC = 16'h0004, ADD = 16'h0008;
    localparam logic [15:0] SUB  = 16'h0010, AND_ = 16'h0020, NOT_ = 16'h0040, RSR = 16'h0080;
    localparam logic [15:0] RSL  = 16'h0100, JMP = 16'h0200, JZ = 16'h0400, JC = 16'h0800;
    localparam logic [15:0] IN_  = 16'h1000, OUT_ = 16'h2000, NOP = 16'h4000, HALT = 16'h8000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dec;
    logic        fz, fc, rdy, step;
    logic        dec_en, ir_ld, opnd_ld, pc_inc, pc_ld, mem_rd, mem_wr, addr_sel, reg_we;
    logic [2:0]  alu_op;
    logic        flag_ld, io_rd, io_wr, halted, fault;

    always #5 clk = ~clk;

    cpu_sequencer #(.TMO_W(4), .TMO_MAX(TMO_MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dec(dec), .i_flag_z(fz), .i_flag_c(fc),
        .i_mem_rdy(rdy), .i_step(step),
        .o_dec_en(dec_en), .o_ir_ld(ir_ld), .o_opnd_ld(opnd_ld), .o_pc_inc(pc_inc),
        .o_pc_ld(pc_ld), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_addr_sel(addr_sel),
        .o_reg_we(reg_we), .o_alu_op(alu_op), .o_flag_ld(flag_ld), .o_io_rd(io_rd),
        .o_io_wr(io_wr), .o_halted(halted), .o_fault(fault)
    );

    stim_t q_stim[$];
    ovec_t q_exp[$];
    ovec_t act[$];
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic ovec_t alu(input logic [2:0] a);
        return {9'b0, a, 5'b0};
    endfunction

    task automatic push(input logic r, input logic [15:0] d, input logic z, input logic c,
                        input logic m, input logic s, input ovec_t e);
        q_stim.push_back('{r, d, z, c, m, s});
        q_exp.push_back(e);
    endtask

    task automatic sticky(input ovec_t v, input int n);
        for (int i = 0; i < n; i++) push(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, v);
    endtask

    // One reset-asserted cycle followed by the IDLE cycle
    task automatic do_reset();
        push(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, A_IDLE);
        push(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, A_IDLE);
    endtask

    // A memory handshake of 'waits' not-ready cycles; TMO_MAX or more waits ends in FAULT
    task automatic mem_phase(input int waits, input ovec_t wait_v, input ovec_t rdy_v, output bit faulted);
        faulted = 1'b0;
        for (int i = 0; i < waits && i < TMO_MAX; i++)
            push(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, wait_v);
        if (waits >= TMO_MAX) begin
            faulted = 1'b1;
            sticky(A_IDLE | O_FAULT, 3);
        end else begin
            push(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, rdy_v);
        end
    endtask

    function automatic ovec_t exec_vec(input logic [15:0] d, input logic z, input logic c);
        case (d)
            MOVA: return alu(3'b000) | O_REG_WE;
            ADD:  return alu(3'b001) | O_REG_WE | O_FLAG_LD;
            SUB:  return alu(3'b010) | O_REG_WE | O_FLAG_LD;
            AND_: return alu(3'b011) | O_REG_WE | O_FLAG_LD;
            NOT_: return alu(3'b100) | O_REG_WE | O_FLAG_LD;
            RSR:  return alu(3'b101) | O_REG_WE | O_FLAG_LD;
            RSL:  return alu(3'b110) | O_REG_WE | O_FLAG_LD;
            JMP:  return A_IDLE | O_PC_LD;
            JZ:   return A_IDLE | (z ? O_PC_LD : 17'h0);
            JC:   return A_IDLE | (c ? O_PC_LD : 17'h0);
            IN_:  return A_IDLE | O_IO_RD | O_REG_WE;
            OUT_: return A_IDLE | O_IO_WR;
            default: return A_IDLE;
        endcase
    endfunction

    // Expand one instruction into its expected per-cycle output sequence
    task automatic run_instr(input logic [15:0] d, input logic z, input logic c,
                             input int wf, input int wo, input int wm);
        bit    f;
        ovec_t base;
        mem_phase(wf, A_IDLE | O_MEM_RD, A_IDLE | O_MEM_RD | O_IR_LD | O_PC_INC, f);
        if (f) return;
        push(1'b1, d, 1'b1, 1'b1, 1'b1, 1'b1, A_IDLE | O_DEC_EN);
        if ($countones(d) > 1) begin
            sticky(A_IDLE | O_FAULT, 3);
            return;
        end
        if ((d & (JMP | JZ | JC | MOVB | MOVC)) != 16'h0) begin
            mem_phase(wo, A_IDLE | O_MEM_RD, A_IDLE | O_MEM_RD | O_OPND_LD | O_PC_INC, f);
            if (f) return;
        end
        if ((d & (MOVB | MOVC)) != 16'h0) begin
            base = A_IDLE | O_ADDR_SEL | ((d == MOVB) ? O_MEM_WR : O_MEM_RD);
            mem_phase(wm, base, base | ((d == MOVC) ? O_REG_WE : 17'h0), f);
            if (f) return;
        end else begin
            push(1'b1, 16'hFFFF, z, c, 1'b1, 1'b1, exec_vec(d, z, c));
            if (d == HALT) begin
                sticky(A_IDLE | O_HALTED, 3);
                return;
            end
        end
`ifdef SEQ_SINGLE_STEP_EN
        push(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, A_IDLE);
        push(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, A_IDLE);
`endif
    endtask

    function automatic int cnt(input int lo, input int hi, input ovec_t mask);
        int n = 0;
        for (int i = lo; i < hi; i++) if ((act[i] & mask) == mask) n++;
        return n;
    endfunction

    task automatic lit(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, got, want);
        end
    endtask

    int j0s, j0e, j1s, j1e, ms, me, hs, he, ss, rs;
    ovec_t o;

    initial begin
        rst_n = 1'b0; dec = 16'h0; fz = 1'b0; fc = 1'b0; rdy = 1'b0; step = 1'b0;

        do_reset();
        run_instr(ADD, 1, 1, 0, 0, 0);
        run_instr(SUB, 1, 1, 1, 0, 0);
        run_instr(AND_, 0, 0, 0, 0, 0);
        run_instr(NOT_, 1, 1, 2, 0, 0);
        run_instr(RSR, 1, 1, 0, 0, 0);
        run_instr(RSL, 1, 1, 0, 0, 0);
        run_instr(MOVA, 1, 1, 0, 0, 0);
        run_instr(IN_, 1, 1, 0, 0, 0);
        run_instr(OUT_, 1, 1, 0, 0, 0);
        run_instr(NOP, 1, 1, 0, 0, 0);
        run_instr(16'h0000, 1, 1, 0, 0, 0);
        j0s = q_exp.size(); run_instr(JZ, 0, 1, 0, 0, 0); j0e = q_exp.size();
        j1s = q_exp.size(); run_instr(JZ, 1, 0, 0, 0, 0); j1e = q_exp.size();
        run_instr(JC, 0, 1, 0, 2, 0);
        run_instr(JC, 1, 0, 1, 0, 0);
        run_instr(JMP, 0, 0, 0, 0, 0);
        run_instr(MOVB, 1, 1, 0, 1, 2);
        ms = q_exp.size(); run_instr(MOVC, 1, 1, 0, 0, 3); me = q_exp.size();
        run_instr(ADD, 0, 0, TMO_MAX - 1, 0, 0);
        run_instr(MOVB, 1, 1, 0, TMO_MAX - 1, TMO_MAX - 1);
        hs = q_exp.size(); run_instr(HALT, 1, 1, 0, 0, 0); he = q_exp.size();
        do_reset();
        run_instr(16'h0003, 1, 1, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) push(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, A_IDLE | O_MEM_RD);
        do_reset();
        ss = q_exp.size(); run_instr(NOP, 1, 1, TMO_MAX, 0, 0);
        rs = q_exp.size(); do_reset();
        run_instr(MOVC, 1, 1, 0, 0, TMO_MAX);
        do_reset();
        run_instr(NOP, 1, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        for (int c = 0; c < q_stim.size(); c++) begin
            @(posedge clk);
            #1;
            rst_n = q_stim[c].rst_n;
            dec   = q_stim[c].dec;
            fz    = q_stim[c].fz;
            fc    = q_stim[c].fc;
            rdy   = q_stim[c].rdy;
            step  = q_stim[c].step;
            @(negedge clk);
            o = {dec_en, ir_ld, opnd_ld, pc_inc, pc_ld, mem_rd, mem_wr, addr_sel, reg_we,
                 alu_op, flag_ld, io_rd, io_wr, halted, fault};
            act.push_back(o);
            n_cmp++;
            if (o !== q_exp[c]) begin
                n_err++;
                $display("FAIL cycle%0d outputs: actual=%05h required=%05h", c, o, q_exp[c]);
            end
        end

        lit("reset_outputs", int'(act[0]), int'(A_IDLE));
        lit("cyc1_ir_ld", int'(act[2][15]), 1);
        lit("cyc2_dec_en", int'(act[3][16]), 1);
        lit("cyc3_alu_add", int'(act[4][7:5]), 1);
        lit("cyc3_reg_we_flag_ld", int'({act[4][8], act[4][4]}), 3);
`ifndef SEQ_SINGLE_STEP_EN
        lit("cyc4_mem_rd", int'(act[5][11]), 1);
`endif
        lit("jz_nt_cyc4_pc_ld", int'(act[j0s + 3][12]), 0);
        lit("jz_t_cyc4_pc_ld", int'(act[j1s + 3][12]), 1);
        lit("jz_nt_pc_inc_count", cnt(j0s, j0e, O_PC_INC), 2);
        lit("jz_t_pc_inc_count", cnt(j1s, j1e, O_PC_INC), 2);
        lit("movc_mem_rd_addr_sel", cnt(ms, me, O_MEM_RD | O_ADDR_SEL), 4);
        lit("movc_reg_we_count", cnt(ms, me, O_REG_WE), 1);
        lit("halt_no_mem_rd", cnt(hs + 4, he, O_MEM_RD), 0);
        lit("halt_sticky", cnt(hs + 4, he, O_HALTED), he - hs - 4);
        lit("tmo_before_12", int'(act[ss + TMO_MAX - 1][0]), 0);
        lit("tmo_at_12", int'(act[ss + TMO_MAX][0]), 1);
        lit("tmo_sticky", int'(act[ss + TMO_MAX + 2][0]), 1);
        lit("reset_after_fault", int'(act[rs]), int'(A_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
